// File: rtl/coin_payout.sv
// Change-return controller: pays out florins first, then shillings, one hopper handshake per coin.
// Optional hopper watchdog and FAULT state are compiled in with `define PAYOUT_TIMEOUT_EN.
module coin_payout #(
    parameter int AMOUNT_W       = 4,
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clock_50MHz,
    input  logic                async_Reset,
    input  logic                payout_start,
    input  logic [AMOUNT_W-1:0] change_amount,
    input  logic                hopper_ack,
    output logic                florin_Eject,
    output logic                shilling_Eject,
    output logic                busy,
    output logic                payout_done,
    output logic [AMOUNT_W-1:0] coins_paid,
    output logic                payout_fault
);

    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

    if (PULSE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("coin_payout: PULSE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        DECIDE,
        EJECT,
        WAIT_ACK,
        DONE
`ifdef PAYOUT_TIMEOUT_EN
        , FAULT
`endif
    } state_t;

    function automatic logic [AMOUNT_W-1:0] coin_value(input logic florin);
        return florin ? AMOUNT_W'(2) : AMOUNT_W'(1);
    endfunction

    state_t              state, state_n;
    logic [AMOUNT_W-1:0] remaining, remaining_n;
    logic [AMOUNT_W-1:0] paid_n;
    logic                florin_sel, florin_sel_n;
    logic [PW-1:0]       pulse_cnt, pulse_cnt_n;
    logic                florin_n, shilling_n, busy_n, done_n;

`ifdef PAYOUT_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wd_cnt, wd_cnt_n;
    logic          fault_q, fault_n;
    assign payout_fault = fault_q;
`else
    assign payout_fault = 1'b0;
`endif

    always_ff @(posedge clock_50MHz or posedge async_Reset) begin
        if (async_Reset) begin
            state          <= IDLE;
            remaining      <= '0;
            coins_paid     <= '0;
            florin_sel     <= 1'b0;
            pulse_cnt      <= '0;
            florin_Eject   <= 1'b0;
            shilling_Eject <= 1'b0;
            busy           <= 1'b0;
            payout_done    <= 1'b0;
`ifdef PAYOUT_TIMEOUT_EN
            wd_cnt         <= '0;
            fault_q        <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            remaining      <= remaining_n;
            coins_paid     <= paid_n;
            florin_sel     <= florin_sel_n;
            pulse_cnt      <= pulse_cnt_n;
            florin_Eject   <= florin_n;
            shilling_Eject <= shilling_n;
            busy           <= busy_n;
            payout_done    <= done_n;
`ifdef PAYOUT_TIMEOUT_EN
            wd_cnt         <= wd_cnt_n;
            fault_q        <= fault_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        remaining_n  = remaining;
        paid_n       = coins_paid;
        florin_sel_n = florin_sel;
        pulse_cnt_n  = pulse_cnt;
`ifdef PAYOUT_TIMEOUT_EN
        wd_cnt_n     = wd_cnt;
        fault_n      = fault_q;
`endif
        case (state)
            IDLE: begin
                if (payout_start) begin
                    remaining_n = change_amount;
                    paid_n      = '0;
                    state_n     = DECIDE;
                end
            end
            DECIDE: begin
                if (remaining == '0) begin
                    state_n = DONE;
                end else begin
                    florin_sel_n = (remaining >= AMOUNT_W'(2));
                    pulse_cnt_n  = '0;
                    state_n      = EJECT;
                end
            end
            EJECT: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_n = WAIT_ACK;
`ifdef PAYOUT_TIMEOUT_EN
                    wd_cnt_n = '0;
`endif
                end else begin
                    pulse_cnt_n = pulse_cnt + PW'(1);
                end
            end
            WAIT_ACK: begin
                // Ack wins over a concurrent start, which is simply not looked at here.
                if (hopper_ack) begin
                    remaining_n = remaining - coin_value(florin_sel);
                    paid_n      = coins_paid + coin_value(florin_sel);
                    state_n     = DECIDE;
                end
`ifdef PAYOUT_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) begin
                    fault_n = 1'b1;
                    state_n = FAULT;
                end else begin
                    wd_cnt_n = wd_cnt + WW'(1);
                end
`endif
            end
            DONE: state_n = IDLE;
`ifdef PAYOUT_TIMEOUT_EN
            FAULT: begin
                if (payout_start) begin
                    remaining_n = change_amount;
                    paid_n      = '0;
                    fault_n     = 1'b0;
                    state_n     = DECIDE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        busy_n     = (state_n == DECIDE) || (state_n == EJECT) || (state_n == WAIT_ACK);
        florin_n   = (state_n == EJECT) && florin_sel_n;
        shilling_n = (state_n == EJECT) && !florin_sel_n;
        done_n     = (state_n == DONE);
    end

endmodule

// File: tb/tb_coin_payout.sv
// Directed bench for coin_payout: a hopper model answers strobes and a monitor scores coins and totals.
module tb_coin_payout;

    localparam int P = 4;
    localparam int T = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] amount = '0;
    logic       ack = 1'b0;
    logic       florin, shilling, busy, done, fault;
    logic [3:0] coins_paid;

    int checks = 0;
    int failures = 0;
    int coin_q[$];
    int total_q[$];
    int hop_mode = 0;  // 0 silent, 1 ack once after each strobe, 2 ack held high

    coin_payout #(.AMOUNT_W(4), .PULSE_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
        .clock_50MHz(clk),
        .async_Reset(rst),
        .payout_start(start),
        .change_amount(amount),
        .hopper_ack(ack),
        .florin_Eject(florin),
        .shilling_Eject(shilling),
        .busy(busy),
        .payout_done(done),
        .coins_paid(coins_paid),
        .payout_fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start for one cycle; returns in the cycle after the accepting edge.
    task automatic start_payout(input logic [3:0] amt);
        @(negedge clk);
        start  = 1'b1;
        amount = amt;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int off0, input int exp_off);
        int off = off0;
        while (!done && off < 200) begin
            @(negedge clk);
            off++;
        end
        check(tag, off, exp_off);
        @(negedge clk);
        check({tag, "_single"}, done, 1'b0);
    endtask

    // Hopper model
    initial begin
        logic was_on = 1'b0;
        forever begin
            @(negedge clk);
            case (hop_mode)
                1:       ack = was_on && !(florin || shilling);
                2:       ack = 1'b1;
                default: ack = 1'b0;
            endcase
            was_on = florin || shilling;
        end
    end

    // Scoreboard monitor
    initial begin
        logic pf = 1'b0;
        logic ps = 1'b0;
        int   len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pf = 1'b0; ps = 1'b0; len = 0;
            end else begin
                if (florin && !pf) begin
                    check("coin_expected", coin_q.size() != 0, 1'b1);
                    if (coin_q.size() != 0) check("coin_florin", 2, coin_q.pop_front());
                    check("one_hot_f", shilling, 1'b0);
                end
                if (shilling && !ps) begin
                    check("coin_expected", coin_q.size() != 0, 1'b1);
                    if (coin_q.size() != 0) check("coin_shilling", 1, coin_q.pop_front());
                    check("one_hot_s", florin, 1'b0);
                end
                if (florin || shilling) len++;
                else if (pf || ps) begin
                    check("strobe_len", len, P);
                    len = 0;
                end
                if (done) begin
                    check("done_expected", total_q.size() != 0, 1'b1);
                    if (total_q.size() != 0) check("paid_at_done", coins_paid, total_q.pop_front());
                    check("busy_at_done", busy, 1'b0);
                end
                pf = florin;
                ps = shilling;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_florin", florin, 1'b0);
        check("rst_shilling", shilling, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_paid", coins_paid, 4'd0);
        check("rst_fault", fault, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Amount 5: florin, florin, shilling
        hop_mode = 1;
        coin_q.push_back(2); coin_q.push_back(2); coin_q.push_back(1);
        total_q.push_back(5);
        start_payout(4'd5);
        check("a5_busy_n1", busy, 1'b1);
        check("a5_idle_strobe_n1", florin, 1'b0);
        @(negedge clk);
        check("a5_florin_n2", florin, 1'b1);
        wait_done("a5_done_cycle", 2, 2 + 3 * (P + 2));

        // Amount 0
        total_q.push_back(0);
        start_payout(4'd0);
        check("a0_busy_n1", busy, 1'b1);
        wait_done("a0_done_cycle", 1, 2);

        // Start while busy is ignored
        coin_q.push_back(2); coin_q.push_back(2); coin_q.push_back(1);
        total_q.push_back(5);
        start_payout(4'd5);
        @(negedge clk);
        start = 1'b1; amount = 4'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("retrig_done_cycle", 3, 2 + 3 * (P + 2));

        // Ack held high: ignored during EJECT
        hop_mode = 2;
        coin_q.push_back(2); coin_q.push_back(1);
        total_q.push_back(3);
        start_payout(4'd3);
        wait_done("held_done_cycle", 1, 2 + 2 * (P + 2));
        hop_mode = 1;

        // Reset in the middle of a florin strobe
        hop_mode = 0;
        coin_q.push_back(2);
        start_payout(4'd4);
        @(negedge clk);
        check("rst_mid_florin_on", florin, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("rst_mid_florin", florin, 1'b0);
        check("rst_mid_shilling", shilling, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_paid", coins_paid, 4'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_after_busy", busy, 1'b0);
        check("rst_after_done", done, 1'b0);

`ifdef PAYOUT_TIMEOUT_EN
        // Hopper never answers
        coin_q.push_back(2);
        start_payout(4'd2);
        repeat (14) @(negedge clk);
        check("to_last_wait_busy", busy, 1'b1);
        check("to_last_wait_fault", fault, 1'b0);
        @(negedge clk);
        check("to_fault", fault, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_paid", coins_paid, 4'd0);
        repeat (5) @(negedge clk);
        check("to_fault_sticky", fault, 1'b1);
        hop_mode = 1;
        coin_q.push_back(1);
        total_q.push_back(1);
        start_payout(4'd1);
        check("to_fault_cleared", fault, 1'b0);
        check("to_restart_busy", busy, 1'b1);
        wait_done("to_restart_done_cycle", 1, 2 + (P + 2));
`else
        check("fault_tied_low", fault, 1'b0);
`endif

        check("coin_q_drained", coin_q.size(), 0);
        check("total_q_drained", total_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
